// File: rtl/md5c_pkg.sv
// Shared definitions for the MD5 cracker command path: frame constants,
// opcodes (also used by the tx-side response serializer) and parser states.
package md5c_pkg;

    localparam logic [7:0] CMD_SOF     = 8'hA5;

    localparam logic [7:0] OP_SET_HASH = 8'h01;
    localparam logic [7:0] OP_START    = 8'h02;
    localparam logic [7:0] OP_STATUS   = 8'h03;

    typedef enum logic [2:0] {
        S_HUNT,
        S_OP,
        S_LEN,
        S_PAY,
        S_CHK,
        S_VALID
    } parser_state_t;

endpackage

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: consumes bytes over the UART rdy/rdy_clr handshake and
// assembles SOF|OP|LEN|payload|CHK frames into a valid/ready command.
// Optional feature: define CMD_TIMEOUT_EN to abort a partial frame after
// TIMEOUT_CYCLES idle cycles (err_timeout pulse); otherwise err_timeout is 0.
module uart_cmd_parser
    import md5c_pkg::*;
#(
    parameter int MAX_PAYLOAD = 16
`ifdef CMD_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 5000000
`endif
) (
    input  logic                     clk_50m,
    input  logic                     rst_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_rdy,
    output logic                     rx_rdy_clr,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [7:0]               cmd_op,
    output logic [7:0]               cmd_len,
    output logic [8*MAX_PAYLOAD-1:0] cmd_payload,
    output logic                     err_chk,
    output logic                     err_len,
    output logic                     err_timeout
);

    localparam int IDX_W = $clog2(MAX_PAYLOAD + 1);

    parser_state_t    state;
    logic [IDX_W-1:0] idx;
    logic [7:0]       acc;
    logic             consume;

`ifdef CMD_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt;
`else
    assign err_timeout = 1'b0;
`endif

    // rx_rdy_clr masks the byte still showing during its own clear pulse
    assign consume = rx_rdy && !rx_rdy_clr && (state != S_VALID);

    // Frame parser FSM with registered handshake, command and error outputs
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_HUNT;
            idx         <= '0;
            acc         <= '0;
            rx_rdy_clr  <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_op      <= '0;
            cmd_len     <= '0;
            cmd_payload <= '0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            err_timeout <= 1'b0;
            tmo_cnt     <= '0;
`endif
        end else begin
            rx_rdy_clr <= consume;
            err_chk    <= 1'b0;
            err_len    <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            if (state == S_VALID) begin
                if (cmd_valid && cmd_ready) begin
                    cmd_valid <= 1'b0;
                    state     <= S_HUNT;
                end
            end else if (consume) begin
                case (state)
                    S_HUNT: begin
                        acc <= '0;
                        if (rx_data == CMD_SOF) state <= S_OP;
                    end
                    S_OP: begin
                        cmd_op <= rx_data;
                        acc    <= rx_data;
                        state  <= S_LEN;
                    end
                    S_LEN: begin
                        acc <= acc ^ rx_data;
                        if (rx_data > 8'(MAX_PAYLOAD)) begin
                            err_len <= 1'b1;
                            state   <= S_HUNT;
                        end else begin
                            // zero-length frames also refresh len/payload so stale data never shows
                            cmd_len     <= rx_data;
                            cmd_payload <= '0;
                            idx         <= '0;
                            state       <= (rx_data == 8'd0) ? S_CHK : S_PAY;
                        end
                    end
                    S_PAY: begin
                        for (int unsigned i = 0; i < MAX_PAYLOAD; i++) begin
                            if (idx == IDX_W'(i)) cmd_payload[8*i +: 8] <= rx_data;
                        end
                        acc <= acc ^ rx_data;
                        idx <= idx + 1'b1;
                        if (8'(idx) == cmd_len - 8'd1) state <= S_CHK;
                    end
                    S_CHK: begin
                        if (rx_data == acc) begin
                            cmd_valid <= 1'b1;
                            state     <= S_VALID;
                        end else begin
                            err_chk <= 1'b1;
                            state   <= S_HUNT;
                        end
                    end
                    default: state <= S_HUNT;
                endcase
            end
`ifdef CMD_TIMEOUT_EN
            // Inter-byte watchdog; only runs while a frame is partially received
            if (consume || state == S_HUNT || state == S_VALID) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_LAST) begin
                tmo_cnt     <= '0;
                err_timeout <= 1'b1;
                state       <= S_HUNT;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
        end
    end

endmodule
